// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state codes, parity
// codes, line-configuration field offsets and the launch byte-lane mapping.
package uart_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_ACK  = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_NONE = 2'b11;

    localparam int BAUD_MSB = 26;
    localparam int BAUD_LSB = 3;
    localparam int STOP_BIT = 2;
    localparam int PAR_MSB  = 1;
    localparam int PAR_LSB  = 0;

    localparam int CFG_W   = 27;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = CFG_W + DATA_W;

    localparam int LAUNCH_CYCLES = 5;

    typedef struct packed {
        logic [CFG_W-1:0]  cfg;
        logic [DATA_W-1:0] data;
    } entry_t;

    // The Encoder latches byte 0 over two presentation cycles, so cnt 0 and 1
    // both select lane 0; later cycles step through lanes 1..3.
    function automatic logic [1:0] launch_lane(input logic [2:0] cnt);
        logic [2:0] shifted;
        shifted = cnt - 3'd1;
        return (cnt <= 3'd1) ? 2'd0 : shifted[1:0];
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO of tagged words for the UART transmit scheduler, with
// full/empty/level status and a single-cycle flush that wins over a push.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 59
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Head is read straight from the array so the scheduler can pop and load
    // its launch register in the same cycle it decides to launch.
    assign head = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: queues tagged words and feeds them one at a time to
// the Encoder. Define UART_TXS_IRQ_EN to add the queue-drained irq output.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [31:0]            wr_data,
    input  logic [26:0]            wr_cfg,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   ovf,
    output logic                   err,
    output logic [15:0]            words_sent,
    output logic [7:0]             enc_data,
    output logic                   enc_en,
    output logic [1:0]             enc_parity,
    output logic                   enc_stop_sel,
    output logic [23:0]            enc_baudcontrol,
    input  logic                   enc_rdy
`ifdef UART_TXS_IRQ_EN
    ,
    output logic                   irq
`endif
);

    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic [2:0]    cnt_reg;
    logic [TW-1:0] tmo_reg;
    logic [31:0]   data_reg;
    logic [23:0]   baud_reg;
    logic          stop_reg;
    logic [1:0]    par_reg;
    logic          ovf_reg;
    logic          err_reg;
    logic [15:0]   words_reg;

    logic          pop;
    logic          timeout;
    logic          done;

    entry_t        wr_entry;
    entry_t        head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    lanes [4];

    assign wr_entry = '{cfg: wr_cfg, data: wr_data};

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_entry),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = data_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            tmo_reg   <= '0;
            data_reg  <= '0;
            baud_reg  <= '0;
            stop_reg  <= 1'b0;
            par_reg   <= '0;
            ovf_reg   <= 1'b0;
            err_reg   <= 1'b0;
            words_reg <= '0;
        end else begin
            state_reg <= state_next;
            // Line config only changes on a pop, so it stays stable for the
            // whole time the Encoder is shifting the previous word out.
            if (pop) begin
                data_reg <= head.data;
                baud_reg <= head.cfg[BAUD_MSB:BAUD_LSB];
                stop_reg <= head.cfg[STOP_BIT];
                par_reg  <= head.cfg[PAR_MSB:PAR_LSB];
                cnt_reg  <= '0;
            end else if (state_reg == LAUNCH) begin
                cnt_reg <= cnt_reg + 3'd1;
            end
            if (state_reg == LAUNCH) begin
                tmo_reg <= '0;
            end else if (state_reg == WAIT_ACK) begin
                tmo_reg <= tmo_reg + 1'b1;
            end
            if (wr_en && fifo_full) begin
                ovf_reg <= 1'b1;
            end
            if (timeout) begin
                err_reg <= 1'b1;
            end
            if (done) begin
                words_reg <= words_reg + 16'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        timeout    = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty && enc_rdy) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                if (cnt_reg == 3'(LAUNCH_CYCLES - 1)) begin
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!enc_rdy) begin
                    state_next = WAIT_DONE;
                end else if (tmo_reg == TW'(ACK_TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (enc_rdy) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        enc_en   = 1'b0;
        enc_data = '0;
        if (state_reg == LAUNCH) begin
            enc_en   = 1'b1;
            enc_data = lanes[launch_lane(cnt_reg)];
        end
    end

    assign busy            = (state_reg != IDLE);
    assign full            = fifo_full;
    assign empty           = fifo_empty;
    assign ovf             = ovf_reg;
    assign err             = err_reg;
    assign words_sent      = words_reg;
    assign enc_baudcontrol = baud_reg;
    assign enc_stop_sel    = stop_reg;
    assign enc_parity      = par_reg;

`ifdef UART_TXS_IRQ_EN
    logic irq_reg;

    // Drained means nothing is left after this edge: either the queue was
    // already empty with no push arriving, or a flush is wiping it now.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= done && (flush || (fifo_empty && !wr_en));
        end
    end

    assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed vector table, randomized
// traffic against a queue model, and hand sequences for overflow/flush/timeout/reset.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [26:0] wr_cfg;
    logic        flush;
    logic        full;
    logic        empty;
    logic [2:0]  level;
    logic        busy;
    logic        ovf;
    logic        err;
    logic [15:0] words_sent;
    logic [7:0]  enc_data;
    logic        enc_en;
    logic [1:0]  enc_parity;
    logic        enc_stop_sel;
    logic [23:0] enc_baudcontrol;
    logic        enc_rdy;
`ifdef UART_TXS_IRQ_EN
    logic        irq;
    int          irq_count = 0;
`endif

    always #5 clk = ~clk;

    uart_tx_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .wr_cfg          (wr_cfg),
        .flush           (flush),
        .full            (full),
        .empty           (empty),
        .level           (level),
        .busy            (busy),
        .ovf             (ovf),
        .err             (err),
        .words_sent      (words_sent),
        .enc_data        (enc_data),
        .enc_en          (enc_en),
        .enc_parity      (enc_parity),
        .enc_stop_sel    (enc_stop_sel),
        .enc_baudcontrol (enc_baudcontrol),
        .enc_rdy         (enc_rdy)
`ifdef UART_TXS_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    typedef struct {
        logic [39:0] seq;
        logic [26:0] cfg;
        int          len;
    } launch_t;

    typedef struct {
        logic [31:0] data;
        logic [26:0] cfg;
        logic [39:0] seq;
        logic [23:0] baud;
        logic        stop;
        logic [1:0]  par;
    } vec_t;

    launch_t     launched[$];
    launch_t     mon_rec;
    bit          auto_enc = 1'b0;
    int          en_run = 0;
    int          busy_cnt = 0;
    logic [39:0] cur_seq;
    logic [26:0] cur_cfg;

    // Encoder stand-in plus launch monitor. In auto mode it goes busy after each
    // full 5-cycle presentation and comes back ready a random time later.
    always @(negedge clk) begin
`ifdef UART_TXS_IRQ_EN
        if (irq === 1'b1) irq_count++;
`endif
        if (auto_enc && busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                enc_rdy = 1'b1;
                if (launched.size() > 0)
                    check("cfg_hold", {enc_baudcontrol, enc_stop_sel, enc_parity}, launched[$].cfg);
            end
        end
        if (enc_en === 1'b1) begin
            if (en_run == 0) cur_cfg = {enc_baudcontrol, enc_stop_sel, enc_parity};
            if (en_run < 5) cur_seq[8*en_run +: 8] = enc_data;
            en_run++;
        end else if (en_run > 0) begin
            if (rst !== 1'b1) begin
                mon_rec.seq = cur_seq;
                mon_rec.cfg = cur_cfg;
                mon_rec.len = en_run;
                check("launch_len", en_run, 5);
                check("byte0_repeat", cur_seq[15:8], cur_seq[7:0]);
                launched.push_back(mon_rec);
                if (auto_enc) begin
                    enc_rdy  = 1'b0;
                    busy_cnt = $urandom_range(2, 12);
                end
            end
            en_run = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [26:0] c);
        wr_en   = 1'b1;
        wr_data = d;
        wr_cfg  = c;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_sent(input logic [15:0] target, input int budget);
        int n;
        n = 0;
        while (words_sent !== target && n < budget) begin
            tick();
            n++;
        end
        check("words_sent", words_sent, target);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_enc_en"}, enc_en, 0);
        check({tag, "_enc_data"}, enc_data, 0);
        check({tag, "_baud"}, enc_baudcontrol, 0);
        check({tag, "_parity"}, enc_parity, 0);
        check({tag, "_stop"}, enc_stop_sel, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_words_sent"}, words_sent, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[4];
        launch_t     exp_q[$];
        launch_t     exp_rec;
        int          n;
        logic [15:0] sent;
        logic [31:0] d;
        logic [26:0] c;

        vecs[0] = '{32'hADE1B055, {24'd434,  1'b0, 2'b01}, 40'hAD_E1_B0_55_55, 24'd434,  1'b0, 2'b01};
        vecs[1] = '{32'hC0B1D190, {24'd434,  1'b1, 2'b10}, 40'hC0_B1_D1_90_90, 24'd434,  1'b1, 2'b10};
        vecs[2] = '{32'hCAFEC0C0, {24'd5207, 1'b1, 2'b11}, 40'hCA_FE_C0_C0_C0, 24'd5207, 1'b1, 2'b11};
        vecs[3] = '{32'h0000FF01, {24'hFFFFFF, 1'b0, 2'b00}, 40'h00_00_FF_01_01, 24'hFFFFFF, 1'b0, 2'b00};

        rst = 1'b1; wr_en = 1'b0; flush = 1'b0; enc_rdy = 1'b1;
        wr_data = '0; wr_cfg = '0;
        tick(); tick();
        check_reset("init");
        rst = 1'b0;
        auto_enc = 1'b1;
        tick();
        sent = 16'd0;

        // Directed vectors: latency, byte order and config, one word at a time.
        for (int i = 0; i < 4; i++) begin
            launched.delete();
            push(vecs[i].data, vecs[i].cfg);
            n = 1;
            while (enc_en !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check("launch_latency", n, 2);
            sent = sent + 16'd1;
            wait_sent(sent, 200);
            check("vec_count", launched.size(), 1);
            if (launched.size() > 0) check("vec_seq", launched[0].seq, vecs[i].seq);
            check("vec_baud", enc_baudcontrol, vecs[i].baud);
            check("vec_stop", enc_stop_sel, vecs[i].stop);
            check("vec_par", enc_parity, vecs[i].par);
`ifdef UART_TXS_IRQ_EN
            if (i == 0) begin
                tick(); tick();
                check("irq_count", irq_count, 1);
            end
`endif
        end

        // Randomized traffic: every accepted word must come out in order, intact.
        launched.delete();
        exp_q.delete();
        for (int i = 0; i < 24; i++) begin
            n = $urandom_range(0, 6);
            repeat (n) tick();
            n = 0;
            while (full === 1'b1 && n < 1000) begin
                tick();
                n++;
            end
            d = $urandom;
            c = 27'($urandom);
            push(d, c);
            exp_rec.seq = {d, d[7:0]};
            exp_rec.cfg = c;
            exp_rec.len = 5;
            exp_q.push_back(exp_rec);
        end
        sent = sent + 16'd24;
        wait_sent(sent, 5000);
        check("rand_count", launched.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < launched.size(); i++) begin
            check("rand_seq", launched[i].seq, exp_q[i].seq);
            check("rand_cfg", launched[i].cfg, exp_q[i].cfg);
        end
        check("rand_ovf", ovf, 0);
        check("rand_err", err, 0);

        // Overflow: five pushes into a stalled queue of four.
        auto_enc = 1'b0;
        enc_rdy  = 1'b0;
        launched.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            d = 32'h10203040 + 32'(i);
            c = 27'(i * 1001 + 7);
            push(d, c);
            if (i < 4) begin
                exp_rec.seq = {d, d[7:0]};
                exp_rec.cfg = c;
                exp_q.push_back(exp_rec);
            end
            if (i == 3) begin
                check("ovf_full4", full, 1);
                check("ovf_level4", level, 4);
                check("ovf_before", ovf, 0);
            end
        end
        check("ovf_full", full, 1);
        check("ovf_level", level, 4);
        check("ovf_flag", ovf, 1);
        enc_rdy  = 1'b1;
        auto_enc = 1'b1;
        sent = sent + 16'd4;
        wait_sent(sent, 2000);
        check("ovf_count", launched.size(), 4);
        for (int i = 0; i < 4 && i < launched.size(); i++) begin
            check("ovf_seq", launched[i].seq, exp_q[i].seq);
            check("ovf_cfg", launched[i].cfg, exp_q[i].cfg);
        end

        // Flush during WAIT_DONE of the first word, with a simultaneous push.
        auto_enc = 1'b0;
        enc_rdy  = 1'b1;
        launched.delete();
        push(32'hA1A2A3A4, {24'd100, 1'b0, 2'b01});
        push(32'hB1B2B3B4, {24'd200, 1'b1, 2'b10});
        push(32'hC1C2C3C4, {24'd300, 1'b0, 2'b11});
        n = 0;
        while (launched.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        check("flush_launch", launched.size(), 1);
        enc_rdy = 1'b0;
        tick();
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 32'hDEADBEEF;
        wr_cfg  = {24'd55, 1'b1, 2'b01};
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        check("flush_level", level, 0);
        check("flush_empty", empty, 1);
        check("flush_busy", busy, 1);
        enc_rdy = 1'b1;
        sent = sent + 16'd1;
        wait_sent(sent, 50);
        repeat (20) tick();
        check("flush_no_more", launched.size(), 1);
        if (launched.size() > 0) check("flush_word1", launched[0].seq, 40'hA1A2A3A4A4);
        check("flush_idle", busy, 0);

        // Ack timeout: Encoder never drops ready.
        launched.delete();
        push(32'h55AA55AA, {24'd9, 1'b0, 2'b01});
        n = 0;
        while (launched.size() == 0 && n < 50) begin
            tick();
            n++;
        end
        check("tmo_launch", launched.size(), 1);
        n = 1;
        while (err !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 65);
        check("tmo_err", err, 1);
        check("tmo_idle", busy, 0);
        check("tmo_words", words_sent, sent);

        // Reset in the middle of a launch.
        push(32'h13579BDF, {24'd777, 1'b1, 2'b10});
        n = 0;
        while (enc_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("rst_launch_seen", enc_en, 1);
        tick(); tick();
        rst = 1'b1;
        tick();
        check_reset("midrst");
        rst = 1'b0;
        repeat (3) tick();
        check("post_rst_enc_en", enc_en, 0);
        check("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
